// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus among NUM_SRC result producers. Every producer
// owns a small circular FIFO of {value, reorder} entries. Each cycle at most
// one non-empty FIFO is granted, searching round-robin from r_rr, and its head
// entry is broadcast on the registered CDB outputs.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          asynchronous active-high reset
//   i_rdy          global run enable (low = stall everything)
//   i_jump_rst     synchronous mispredict flush (wins over i_rdy)
//   i_src_send     per-producer push strobe
//   i_src_value    packed 32-bit values, slice i = [32i+31:32i]
//   i_src_reorder  packed ROB tags, slice i = [ROB_W*i+ROB_W-1:ROB_W*i]
//   o_src_full     FIFO i holds DEPTH entries (from registered count)
//   o_cdb_send     registered broadcast valid
//   o_cdb_value    registered broadcast value
//   o_cdb_reorder  registered broadcast ROB tag
//   o_drop_err     sticky: a push arrived while its FIFO was full
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 2,
  parameter int ROB_SIZE_LOG = 4,
  parameter int ROB_W        = ROB_SIZE_LOG
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rdy,
  input  logic                     i_jump_rst,
  input  logic [NUM_SRC-1:0]       i_src_send,
  input  logic [NUM_SRC*32-1:0]    i_src_value,
  input  logic [NUM_SRC*ROB_W-1:0] i_src_reorder,
  output logic [NUM_SRC-1:0]       o_src_full,
  output logic                     o_cdb_send,
  output logic [31:0]              o_cdb_value,
  output logic [ROB_W-1:0]         o_cdb_reorder,
  output logic                     o_drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic               w_run;
  logic [NUM_SRC-1:0] w_not_empty;
  logic [NUM_SRC-1:0] w_drop;
  logic [NUM_SRC-1:0] w_pop;
  logic [31:0]        w_head_val [NUM_SRC];
  logic [ROB_W-1:0]   w_head_tag [NUM_SRC];
  logic [SRC_W-1:0]   r_rr;
  logic [SRC_W-1:0]   w_gnt;
  logic [SRC_W-1:0]   w_rr_next;
  logic               w_found;

  // Flush has priority over stall; both block any push or pop.
  assign w_run = i_rdy & ~i_jump_rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [31:0]      r_mem_val [DEPTH];
      logic [ROB_W-1:0] r_mem_tag [DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_cnt;
      logic             w_push;

      assign o_src_full[gi]  = (r_cnt == FULL_CNT);
      assign w_not_empty[gi] = (r_cnt != '0);
      // Fullness is judged before the edge: a same-cycle pop frees no room.
      assign w_push          = w_run & i_src_send[gi] & ~o_src_full[gi];
      assign w_drop[gi]      = w_run & i_src_send[gi] & o_src_full[gi];
      assign w_pop[gi]       = w_run & w_found & (w_gnt == SRC_W'(gi));
      assign w_head_val[gi]  = r_mem_val[r_rptr];
      assign w_head_tag[gi]  = r_mem_tag[r_rptr];

      // Entry storage needs no reset: the count alone says what is valid.
      always_ff @(posedge i_clk) begin
        if (w_push) begin
          r_mem_val[r_wptr] <= i_src_value[32*gi +: 32];
          r_mem_tag[r_wptr] <= i_src_reorder[ROB_W*gi +: ROB_W];
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else if (i_jump_rst) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop[gi]) r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push, w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin search: walk offsets from the far end so the closest
  // non-empty FIFO to r_rr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_not_empty[(int'(r_rr) + k) % NUM_SRC]) begin
        w_found = 1'b1;
        w_gnt   = SRC_W'((int'(r_rr) + k) % NUM_SRC);
      end
    end
  end

  assign w_rr_next = (w_gnt == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt + SRC_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr          <= '0;
      o_cdb_send    <= 1'b0;
      o_cdb_value   <= '0;
      o_cdb_reorder <= '0;
      o_drop_err    <= 1'b0;
    end else if (i_jump_rst) begin
      // Broadcast payload and the sticky error survive a flush.
      r_rr       <= '0;
      o_cdb_send <= 1'b0;
    end else if (i_rdy) begin
      o_drop_err <= o_drop_err | (|w_drop);
      if (w_found) begin
        o_cdb_send    <= 1'b1;
        o_cdb_value   <= w_head_val[w_gnt];
        o_cdb_reorder <= w_head_tag[w_gnt];
        r_rr          <= w_rr_next;
      end else begin
        o_cdb_send <= 1'b0;
      end
    end else begin
      o_cdb_send <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Applies a table of per-cycle stimulus records to cdb_arbiter (NUM_SRC=2,
// DEPTH=2, ROB_W=4). Each record carries the outputs expected right after
// its edge; that expectation is queued when the record is driven and popped
// when the DUT output is sampled. A hand-written sequence then covers the
// asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_rst;
  logic [1:0]  src_send;
  logic [63:0] src_value;
  logic [7:0]  src_reorder;
  logic [1:0]  src_full;
  logic        cdb_send;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_reorder;
  logic        drop_err;

  cdb_arbiter #(
    .NUM_SRC(2),
    .DEPTH(2),
    .ROB_SIZE_LOG(4),
    .ROB_W(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rdy(rdy),
    .i_jump_rst(jump_rst),
    .i_src_send(src_send),
    .i_src_value(src_value),
    .i_src_reorder(src_reorder),
    .o_src_full(src_full),
    .o_cdb_send(cdb_send),
    .o_cdb_value(cdb_value),
    .o_cdb_reorder(cdb_reorder),
    .o_drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        jr;
    logic [1:0]  send;
    logic [31:0] v0;
    logic [3:0]  t0;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        esend;
    logic [31:0] evalue;
    logic [3:0]  etag;
    logic [1:0]  efull;
    logic        edrop;
  } vec_t;

  // Packed {send, value, tag, full, drop} expectation
  typedef logic [39:0] obs_t;

  localparam int NV = 40;
  vec_t tbl [NV];
  obs_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic j, logic [1:0] s,
                              logic [31:0] a, logic [3:0] ta,
                              logic [31:0] b, logic [3:0] tb,
                              logic es, logic [31:0] ev, logic [3:0] et,
                              logic [1:0] ef, logic ed);
    vec_t v;
    v.rdy = r; v.jr = j; v.send = s;
    v.v0 = a; v.t0 = ta; v.v1 = b; v.t1 = tb;
    v.esend = es; v.evalue = ev; v.etag = et; v.efull = ef; v.edrop = ed;
    return v;
  endfunction

  function automatic obs_t pack(logic s, logic [31:0] v, logic [3:0] t,
                                logic [1:0] f, logic d);
    return {s, v, t, f, d};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got send=%0b value=%h tag=%h full=%b drop=%0b, want send=%0b value=%h tag=%h full=%b drop=%0b",
               name, act[39], act[38:7], act[6:3], act[2:1], act[0],
               exp[39], exp[38:7], exp[6:3], exp[2:1], exp[0]);
    end else begin
      $display("ok   %s: send=%0b value=%h tag=%h full=%b drop=%0b",
               name, act[39], act[38:7], act[6:3], act[2:1], act[0]);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic [1:0] s,
                       input logic [31:0] a, input logic [3:0] ta,
                       input logic [31:0] b, input logic [3:0] tb);
    rdy         = r;
    jump_rst    = j;
    src_send    = s;
    src_value   = {b, a};
    src_reorder = {tb, ta};
  endtask

  initial begin
    // ---- vector table: inputs at an edge, outputs right after it ----
    // single push and its one-cycle broadcast
    tbl[0]  = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h0,    4'h0, 2'b00, 0);
    tbl[1]  = mk(1,0,2'b01, 32'h1234,3, 0,0,        0, 32'h0,    4'h0, 2'b00, 0);
    tbl[2]  = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h1234, 4'h3, 2'b00, 0);
    tbl[3]  = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h1234, 4'h3, 2'b00, 0);
    // flush to bring rr back to 0, then contention twice
    tbl[4]  = mk(1,1,2'b00, 0,0, 0,0,               0, 32'h1234, 4'h3, 2'b00, 0);
    tbl[5]  = mk(1,0,2'b11, 32'hA,1, 32'hB,2,       0, 32'h1234, 4'h3, 2'b00, 0);
    tbl[6]  = mk(1,0,2'b00, 0,0, 0,0,               1, 32'hA,    4'h1, 2'b00, 0);
    tbl[7]  = mk(1,0,2'b00, 0,0, 0,0,               1, 32'hB,    4'h2, 2'b00, 0);
    tbl[8]  = mk(1,0,2'b11, 32'hC,5, 32'hD,6,       0, 32'hB,    4'h2, 2'b00, 0);
    tbl[9]  = mk(1,0,2'b00, 0,0, 0,0,               1, 32'hC,    4'h5, 2'b00, 0);
    tbl[10] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'hD,    4'h6, 2'b00, 0);
    tbl[11] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'hD,    4'h6, 2'b00, 0);
    // both push three times: P1 fills, its third push is dropped
    tbl[12] = mk(1,0,2'b11, 32'h10,1, 32'h20,2,     0, 32'hD,    4'h6, 2'b00, 0);
    tbl[13] = mk(1,0,2'b11, 32'h11,3, 32'h21,4,     1, 32'h10,   4'h1, 2'b10, 0);
    tbl[14] = mk(1,0,2'b11, 32'h12,5, 32'h22,6,     1, 32'h20,   4'h2, 2'b01, 1);
    tbl[15] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h11,   4'h3, 2'b00, 1);
    tbl[16] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h21,   4'h4, 2'b00, 1);
    tbl[17] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h12,   4'h5, 2'b00, 1);
    tbl[18] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h12,   4'h5, 2'b00, 1);
    // stall three cycles with queued entries and ignored pushes
    tbl[19] = mk(1,0,2'b11, 32'h30,1, 32'h40,2,     0, 32'h12,   4'h5, 2'b00, 1);
    tbl[20] = mk(1,0,2'b11, 32'h31,3, 32'h41,4,     1, 32'h40,   4'h2, 2'b01, 1);
    tbl[21] = mk(0,0,2'b11, 32'h77,7, 32'h78,8,     0, 32'h40,   4'h2, 2'b01, 1);
    tbl[22] = mk(0,0,2'b11, 32'h77,7, 32'h78,8,     0, 32'h40,   4'h2, 2'b01, 1);
    tbl[23] = mk(0,0,2'b11, 32'h77,7, 32'h78,8,     0, 32'h40,   4'h2, 2'b01, 1);
    tbl[24] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h30,   4'h1, 2'b00, 1);
    tbl[25] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h41,   4'h4, 2'b00, 1);
    tbl[26] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h31,   4'h3, 2'b00, 1);
    tbl[27] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h31,   4'h3, 2'b00, 1);
    // flush with entries queued and a simultaneous push
    tbl[28] = mk(1,0,2'b11, 32'h50,1, 32'h60,2,     0, 32'h31,   4'h3, 2'b00, 1);
    tbl[29] = mk(1,0,2'b11, 32'h51,3, 32'h61,4,     1, 32'h60,   4'h2, 2'b01, 1);
    tbl[30] = mk(1,0,2'b10, 0,0, 32'h62,5,          1, 32'h50,   4'h1, 2'b10, 1);
    tbl[31] = mk(1,1,2'b11, 32'h70,6, 32'h71,7,     0, 32'h50,   4'h1, 2'b00, 1);
    tbl[32] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h50,   4'h1, 2'b00, 1);
    tbl[33] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h50,   4'h1, 2'b00, 1);
    tbl[34] = mk(1,0,2'b01, 32'h55,7, 0,0,          0, 32'h50,   4'h1, 2'b00, 1);
    tbl[35] = mk(1,0,2'b00, 0,0, 0,0,               1, 32'h55,   4'h7, 2'b00, 1);
    tbl[36] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h55,   4'h7, 2'b00, 1);
    // flush during stall still empties the FIFOs
    tbl[37] = mk(1,0,2'b10, 0,0, 32'h66,8,          0, 32'h55,   4'h7, 2'b00, 1);
    tbl[38] = mk(0,1,2'b00, 0,0, 0,0,               0, 32'h55,   4'h7, 2'b00, 1);
    tbl[39] = mk(1,0,2'b00, 0,0, 0,0,               0, 32'h55,   4'h7, 2'b00, 1);

    // ---- reset state ----
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
    #12;
    chk("reset", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b0, 32'h0, 4'h0, 2'b00, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven vectors through the scoreboard ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rdy, tbl[i].jr, tbl[i].send,
            tbl[i].v0, tbl[i].t0, tbl[i].v1, tbl[i].t1);
      sb.push_back(pack(tbl[i].esend, tbl[i].evalue, tbl[i].etag,
                        tbl[i].efull, tbl[i].edrop));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL vec%0d: scoreboard empty, got send=%0b, want an entry", i, cdb_send);
      end else begin
        chk($sformatf("vec%0d", i),
            pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
            sb.pop_front());
      end
    end

    // ---- async reset while a broadcast is on the bus ----
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b11, 32'h99, 4'h9, 32'h98, 4'h8);
    @(posedge clk);
    #1;
    chk("arst_push", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b0, 32'h55, 4'h7, 2'b00, 1'b1));
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_bcast", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b1, 32'h99, 4'h9, 2'b00, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_async", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b0, 32'h0, 4'h0, 2'b00, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    // the pending P1 entry must be gone
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_lost", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b0, 32'h0, 4'h0, 2'b00, 1'b0));
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 32'hAB, 4'hA, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_first", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b0, 32'h0, 4'h0, 2'b00, 1'b0));
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_resume", pack(cdb_send, cdb_value, cdb_reorder, src_full, drop_err),
        pack(1'b1, 32'hAB, 4'hA, 2'b00, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
